// File: rtl/ram_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter_if
// Brief    : Requester handshake and RAM pin bundle for ram_port_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  Req0;
  logic                  Req1;
  logic                  We0;
  logic                  We1;
  logic [ADDR_WIDTH-1:0] Addr0;
  logic [ADDR_WIDTH-1:0] Addr1;
  logic [DATA_WIDTH-1:0] Wdata0;
  logic [DATA_WIDTH-1:0] Wdata1;
  logic                  Gnt0;
  logic                  Gnt1;
  logic                  Ack0;
  logic                  Ack1;
  logic [DATA_WIDTH-1:0] Rdata;
  logic                  Busy;
  logic [ADDR_WIDTH-1:0] Ram_Addr;
  logic [DATA_WIDTH-1:0] Ram_Din;
  logic                  Ram_We;
  logic                  Ram_Re;
  logic [DATA_WIDTH-1:0] Ram_Dout;

  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, Ram_Dout,
    output Gnt0, Gnt1, Ack0, Ack1, Rdata, Busy, Ram_Addr, Ram_Din, Ram_We, Ram_Re
  );

  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, Ram_Dout,
    input  Gnt0, Gnt1, Ack0, Ack1, Rdata, Busy, Ram_Addr, Ram_Din, Ram_We, Ram_Re
  );
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter
// Brief    : Two-port arbiter (CPU / loader) in front of a single-port RAM.
//            Define ARB_ROUND_ROBIN_EN for round-robin, else port 0 wins ties.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  ram_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t                state_q;
  logic                  sel_q;
  logic                  we_q;
  logic [2:0]            cnt_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic                  busy_q;
  logic                  ram_we_q;
  logic                  ram_re_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_din_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  win_d;
  logic                  sel_we_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;

  // rr_q names the preferred port; it only matters when both ports request.
  always_comb begin
    win_d = bus.Req1;
    if (bus.Req0 && bus.Req1) win_d = rr_q;
  end
`else
  always_comb begin
    win_d = bus.Req1 & ~bus.Req0;
  end
`endif

  always_comb begin
    sel_we_d = win_d ? bus.We1 : bus.We0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 3'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ram_we_q <= 1'b0;
      ram_re_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Req0 || bus.Req1) begin
            sel_q      <= win_d;
            we_q       <= sel_we_d;
            ram_addr_q <= win_d ? bus.Addr1 : bus.Addr0;
            ram_din_q  <= win_d ? bus.Wdata1 : bus.Wdata0;
            ram_we_q   <= sel_we_d;
            ram_re_q   <= !sel_we_d;
            gnt0_q     <= !win_d;
            gnt1_q     <= win_d;
            busy_q     <= 1'b1;
            state_q    <= S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q       <= !win_d;
`endif
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            ack0_q  <= !sel_q;
            ack1_q  <= sel_q;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q <= bus.Ram_Dout;
            ack0_q  <= !sel_q;
            ack1_q  <= sel_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Gnt0     = gnt0_q;
  assign bus.Gnt1     = gnt1_q;
  assign bus.Ack0     = ack0_q;
  assign bus.Ack1     = ack1_q;
  assign bus.Rdata    = rdata_q;
  assign bus.Busy     = busy_q;
  assign bus.Ram_Addr = ram_addr_q;
  assign bus.Ram_Din  = ram_din_q;
  assign bus.Ram_We   = ram_we_q;
  assign bus.Ram_Re   = ram_re_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter (RD_LAT = 3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LAT    (LAT)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  // RAM model: read data appears LAT cycles after the Ram_Re cycle, poison otherwise.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT];

  always @(posedge clk) begin
    if (bus.Ram_We) mem[bus.Ram_Addr] <= bus.Ram_Din;
    pipe[0] <= bus.Ram_Re ? mem[bus.Ram_Addr] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.Ram_Dout = pipe[LAT-1];

  function automatic logic [6:0] ctl();
    return {bus.Gnt0, bus.Gnt1, bus.Ack0, bus.Ack1, bus.Ram_We, bus.Ram_Re, bus.Busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (ctl() !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want %b", ctl(), 7'b0);
    end
    rst = 1'b0;
    repeat (5) tick();
    vectors++;
    if (ctl() !== 7'b0) begin
      miscompares++;
      $display("FAIL idle_ctl: got %b want %b", ctl(), 7'b0);
    end
    vectors++;
    if ({bus.Rdata, bus.Ram_Addr, bus.Ram_Din} !== 40'h0) begin
      miscompares++;
      $display("FAIL idle_data: got %h want 0", {bus.Rdata, bus.Ram_Addr, bus.Ram_Din});
    end
  endtask

  task automatic test_write();
    bus.We0 = 1'b1; bus.Addr0 = 8'h12; bus.Wdata0 = 16'hBEEF; bus.Req0 = 1'b1;
    tick();
    vectors++;
    if (ctl() !== 7'b1000101) begin
      miscompares++;
      $display("FAIL wr_gnt: got %b want %b", ctl(), 7'b1000101);
    end
    vectors++;
    if ({bus.Ram_Addr, bus.Ram_Din} !== {8'h12, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr_bus: got %h want %h", {bus.Ram_Addr, bus.Ram_Din}, {8'h12, 16'hBEEF});
    end
    bus.Req0 = 1'b0;
    tick();
    vectors++;
    if (ctl() !== 7'b0010001) begin
      miscompares++;
      $display("FAIL wr_ack: got %b want %b", ctl(), 7'b0010001);
    end
    tick();
    vectors++;
    if ({ctl(), bus.Rdata} !== {7'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL wr_idle: got %h want 0", {ctl(), bus.Rdata});
    end
  endtask

  task automatic test_read();
    bus.We1 = 1'b0; bus.Addr1 = 8'h12; bus.Req1 = 1'b1;
    tick();
    vectors++;
    if ({ctl(), bus.Ram_Addr} !== {7'b0100011, 8'h12}) begin
      miscompares++;
      $display("FAIL rd_gnt: got %h want %h", {ctl(), bus.Ram_Addr}, {7'b0100011, 8'h12});
    end
    bus.Req1 = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      vectors++;
      if (ctl() !== 7'b0000001) begin
        miscompares++;
        $display("FAIL rd_wait c+%0d: got %b want %b", k, ctl(), 7'b0000001);
      end
    end
    tick();
    vectors++;
    if ({ctl(), bus.Rdata} !== {7'b0001001, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL rd_ack: got %h want %h", {ctl(), bus.Rdata}, {7'b0001001, 16'hBEEF});
    end
    tick();
    vectors++;
    if ({ctl(), bus.Rdata} !== {7'b0, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL rd_hold: got %h want %h", {ctl(), bus.Rdata}, {7'b0, 16'hBEEF});
    end
    // A write must leave Rdata untouched.
    bus.We1 = 1'b1; bus.Addr1 = 8'h34; bus.Wdata1 = 16'h1234; bus.Req1 = 1'b1;
    tick();
    vectors++;
    if ({ctl(), bus.Ram_Addr, bus.Ram_Din} !== {7'b0100101, 8'h34, 16'h1234}) begin
      miscompares++;
      $display("FAIL wr1_gnt: got %h want %h", {ctl(), bus.Ram_Addr, bus.Ram_Din},
               {7'b0100101, 8'h34, 16'h1234});
    end
    bus.Req1 = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ctl(), bus.Rdata} !== {7'b0, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr1_rdata: got %h want %h", {ctl(), bus.Rdata}, {7'b0, 16'hBEEF});
    end
  endtask

  task automatic test_arbitration();
    int   last_cyc;
    int   cyc;
    logic exp_port;
    logic got_port;
    logic found;
    bus.We0 = 1'b1; bus.Addr0 = 8'h20; bus.Wdata0 = 16'h0A0A;
    bus.We1 = 1'b1; bus.Addr1 = 8'h21; bus.Wdata1 = 16'h1B1B;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    cyc = 0;
    last_cyc = -1;
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      got_port = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        tick();
        cyc++;
        if (bus.Gnt0 || bus.Gnt1) begin
          found = 1'b1;
          got_port = bus.Gnt1;
          vectors++;
          if (bus.Gnt0 && bus.Gnt1) begin
            miscompares++;
            $display("FAIL arb_dual_gnt: got Gnt0=1 Gnt1=1 want one-hot");
          end
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = n[0];
`else
      exp_port = 1'b0;
`endif
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL arb_timeout #%0d: got no grant want port %0d", n, exp_port);
      end else if (got_port !== exp_port) begin
        miscompares++;
        $display("FAIL arb_order #%0d: got port %0d want port %0d", n, got_port, exp_port);
      end
      if (found && last_cyc >= 0) begin
        vectors++;
        if (cyc - last_cyc !== 3) begin
          miscompares++;
          $display("FAIL arb_spacing #%0d: got %0d cycles want 3", n, cyc - last_cyc);
        end
      end
      if (found) last_cyc = cyc;
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    repeat (4) tick();
    vectors++;
    if (ctl() !== 7'b0) begin
      miscompares++;
      $display("FAIL arb_drain: got %b want %b", ctl(), 7'b0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic saw_ack;
    bus.We0 = 1'b0; bus.Addr0 = 8'h12; bus.Req0 = 1'b1;
    tick();
    vectors++;
    if (ctl() !== 7'b1000011) begin
      miscompares++;
      $display("FAIL mr_gnt: got %b want %b", ctl(), 7'b1000011);
    end
    bus.Req0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({ctl(), bus.Rdata, bus.Ram_Addr} !== {7'b0, 16'h0, 8'h0}) begin
      miscompares++;
      $display("FAIL mr_reset: got %h want 0", {ctl(), bus.Rdata, bus.Ram_Addr});
    end
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (8) begin
      tick();
      if (bus.Ack0 || bus.Busy) saw_ack = 1'b1;
    end
    vectors++;
    if (saw_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL mr_no_ack: got activity=%b want 0", saw_ack);
    end
  endtask

  task automatic test_busy_pulse();
    logic seen;
    bus.We0 = 1'b1; bus.Addr0 = 8'h40; bus.Wdata0 = 16'h5555; bus.Req0 = 1'b1;
    tick();
    bus.Req0 = 1'b0;
    bus.We1 = 1'b0; bus.Addr1 = 8'h12; bus.Req1 = 1'b1;
    tick();
    bus.Req1 = 1'b0;
    vectors++;
    if (ctl() !== 7'b0010001) begin
      miscompares++;
      $display("FAIL bp_ack0: got %b want %b", ctl(), 7'b0010001);
    end
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.Gnt1 || bus.Ack1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ignored: got port1 activity=%b want 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.We0 = 1'b0; bus.We1 = 1'b0;
    bus.Addr0 = '0; bus.Addr1 = '0; bus.Wdata0 = '0; bus.Wdata1 = '0;
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_reset_mid_read();
    test_busy_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
